// File: rtl/mux_sel_pkg.sv
// Shared constants and state encoding for the round-robin selector and its downstream mux.
package mux_sel_pkg;

  localparam int N_SRC        = 4;
  localparam int SEL_W        = 2;
  localparam int DEF_MAX_HOLD = 8;
  localparam int DEF_CNT_W    = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/mux_sel.sv
// Four-input word mux steered by the arbiter's sel output.
module mux_sel
  import mux_sel_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [W-1:0]     in1,
  input  logic [W-1:0]     in2,
  input  logic [W-1:0]     in3,
  input  logic [W-1:0]     in4,
  output logic [W-1:0]     out
);

  always_comb begin
    unique case (sel)
      2'd0:    out = in1;
      2'd1:    out = in2;
      2'd2:    out = in3;
      default: out = in4;
    endcase
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request starting at ptr, wrapping mod N_SRC.
module rr_pick
  import mux_sel_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  assign any = |req;

  // Scanning from the far end lets the nearest hit to ptr overwrite later ones.
  always_comb begin
    idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[ptr + SEL_W'(i)]) idx = ptr + SEL_W'(i);
    end
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter with a hold limit; all outputs registered, driving mux_sel.sel directly.
module rr_sel_arbiter
  import mux_sel_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req,
  output logic [SEL_W-1:0] sel,
  output logic [N_SRC-1:0] gnt,
  output logic             valid
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   ptr, ptr_nxt;
  logic [CNT_W-1:0]   hold_cnt, hold_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic [N_SRC-1:0]   gnt_nxt;
  logic               valid_nxt;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;
  logic               take;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    take      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (pick_any) take = 1'b1;
      end
      ST_GRANT: begin
        if (!req[sel]) begin
          if (pick_any) take = 1'b1;
          else begin
            state_nxt = ST_IDLE;
            hold_nxt  = '0;
          end
        end else if (hold_cnt == HOLD_LAST) begin
          // ptr sits just past sel, so the search only lands on sel when nobody else waits.
          hold_nxt = '0;
          if ((req & ~gnt) != '0) take = 1'b1;
        end else begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (take) begin
      state_nxt = ST_GRANT;
      sel_nxt   = pick_idx;
      ptr_nxt   = pick_idx + SEL_W'(1);
      hold_nxt  = '0;
    end

    valid_nxt = (state_nxt == ST_GRANT);
    gnt_nxt   = '0;
    if (valid_nxt) gnt_nxt[sel_nxt] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      sel      <= '0;
      gnt      <= '0;
      valid    <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      sel      <= sel_nxt;
      gnt      <= gnt_nxt;
      valid    <= valid_nxt;
    end
  end

endmodule
